// File: rtl/trdb_d5m_pixel_source_if.sv
// TRDB-D5M parallel pixel link: pixel-stream outputs plus the mode and trigger
// controls. The master side is the pixel source.
interface trdb_d5m_pixel_source_if;
  logic        piul1Enable;
  logic        piul1SnapshotMode;
  logic        piul1SnapshotTrigger;
  logic        poul1FrameValid;
  logic        poul1LineValid;
  logic [11:0] poul12PixelData;
  logic        poul1SnapshotStrobe;
  logic [15:0] poul16FrameCount;

  modport master (
    input  piul1Enable, piul1SnapshotMode, piul1SnapshotTrigger,
    output poul1FrameValid, poul1LineValid, poul12PixelData,
           poul1SnapshotStrobe, poul16FrameCount
  );

  modport slave (
    output piul1Enable, piul1SnapshotMode, piul1SnapshotTrigger,
    input  poul1FrameValid, poul1LineValid, poul12PixelData,
           poul1SnapshotStrobe, poul16FrameCount
  );
endinterface

// File: rtl/trdb_d5m_pixel_source.sv
// Pixel-stream generator standing in for the TRDB-D5M sensor pins.
// Define TRDB_D5M_PIXEL_SOURCE_COLORBARS_EN for Bayer colour bars; otherwise a ramp pattern.
module trdb_d5m_pixel_source #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int HBLANK_CC   = 32,
  parameter int VBLANK_CC   = 2000,
  parameter int FV_LEAD_CC  = 4,
  parameter int FV_TRAIL_CC = 4,
  parameter int STROBE_CC   = 8
) (
  input  logic                           piul1Clock,
  input  logic                           piul1Reset_n,
  trdb_d5m_pixel_source_if.master        pix_if
);

  localparam int MAX_A  = (STROBE_CC > FV_LEAD_CC) ? STROBE_CC : FV_LEAD_CC;
  localparam int MAX_B  = (HBLANK_CC > FV_TRAIL_CC) ? HBLANK_CC : FV_TRAIL_CC;
  localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CC = (MAX_C > VBLANK_CC) ? MAX_C : VBLANK_CC;
  localparam int CNT_W  = (MAX_CC > 1) ? $clog2(MAX_CC) : 1;
  localparam int COL_W  = (ACTIVE_COLS > 1) ? $clog2(ACTIVE_COLS) : 1;
  localparam int ROW_W  = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_FV_LEAD, S_ACTIVE, S_HBLANK, S_FV_TRAIL, S_VBLANK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               fv_q, fv_d;
  logic               lv_q, lv_d;
  logic               strobe_q, strobe_d;
  logic [11:0]        pix_q, pix_d;
  logic [11:0]        pattern;
  logic               continuous_go;

  assign continuous_go = !pix_if.piul1SnapshotMode && pix_if.piul1Enable;

  always_ff @(posedge piul1Clock) begin
    if (!piul1Reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
      fv_q          <= 1'b0;
      lv_q          <= 1'b0;
      strobe_q      <= 1'b0;
      pix_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
      fv_q          <= fv_d;
      lv_q          <= lv_d;
      strobe_q      <= strobe_d;
      pix_q         <= pix_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    col_d         = col_q;
    row_d         = row_q;
    frame_count_d = frame_count_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (continuous_go) begin
          state_d = S_FV_LEAD;
        end else if (pix_if.piul1SnapshotMode && pix_if.piul1SnapshotTrigger) begin
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CC - 1)) begin
          state_d = S_FV_LEAD;
          cnt_d   = '0;
        end
      end
      S_FV_LEAD: begin
        if (cnt_q == CNT_W'(FV_LEAD_CC - 1)) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          col_d   = '0;
        end
      end
      S_ACTIVE: begin
        // The column counter times the line; cnt stays parked at zero.
        cnt_d = '0;
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(ACTIVE_COLS - 1)) begin
          col_d   = '0;
          state_d = (row_q == ROW_W'(ACTIVE_ROWS - 1)) ? S_FV_TRAIL : S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (cnt_q == CNT_W'(HBLANK_CC - 1)) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          row_d   = row_q + ROW_W'(1);
        end
      end
      S_FV_TRAIL: begin
        if (cnt_q == CNT_W'(FV_TRAIL_CC - 1)) begin
          state_d       = S_VBLANK;
          cnt_d         = '0;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == CNT_W'(VBLANK_CC - 1)) begin
          state_d = continuous_go ? S_FV_LEAD : S_IDLE;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef TRDB_D5M_PIXEL_SOURCE_COLORBARS_EN
  localparam int BAR_W = ACTIVE_COLS / 8;

  logic [2:0] bar_idx;
  logic       comp_on;

  // Bar index bits encode colour: R absent for bars 2,3,6,7; G for 4..7; B for odd bars.
  always_comb begin
    bar_idx = 3'(col_d / COL_W'(BAR_W));
    comp_on = 1'b0;
    case ({row_d[0], col_d[0]})
      2'b00:   comp_on = ~bar_idx[2];
      2'b01:   comp_on = ~bar_idx[1];
      2'b10:   comp_on = ~bar_idx[0];
      default: comp_on = ~bar_idx[2];
    endcase
    pattern = {12{comp_on}};
  end
`else
  always_comb begin
    pattern = 12'(32'(row_d) + 32'(col_d) + 32'(frame_count_d));
  end
`endif

  // Outputs are decoded from the next state so every pin comes straight from a flop.
  always_comb begin
    fv_d     = state_d inside {S_FV_LEAD, S_ACTIVE, S_HBLANK, S_FV_TRAIL};
    lv_d     = (state_d == S_ACTIVE);
    strobe_d = (state_d == S_STROBE);
    pix_d    = lv_d ? pattern : 12'd0;
  end

  assign pix_if.poul1FrameValid     = fv_q;
  assign pix_if.poul1LineValid      = lv_q;
  assign pix_if.poul12PixelData     = pix_q;
  assign pix_if.poul1SnapshotStrobe = strobe_q;
  assign pix_if.poul16FrameCount    = frame_count_q;

endmodule

// File: doc/trdb_d5m_pixel_source.md
# trdb_d5m_pixel_source

Synthesizable pixel-stream generator that drives the TRDB-D5M parallel pixel interface: frame valid, line valid, 12-bit pixel data and snapshot strobe. It is the transmitting end of the link the image sensor driver receives on. It replaces the sensor pin inputs for bring-up, so the frame path and VGA output can run without a camera. It also serves as the stimulus source for sensor-driver benches. It runs in the system clock domain.

## Interface
- ACTIVE_COLS, 640: active pixels per line; ≥ 8 and multiple of 8 when colour bars are compiled in
- ACTIVE_ROWS, 480: active lines per frame; ≥ 1
- HBLANK_CC, 32: cycles between lines, LineValid low and FrameValid high; ≥ 1
- VBLANK_CC, 2000: cycles with FrameValid low between frames; ≥ 1
- FV_LEAD_CC, 4: cycles with FrameValid high before first LineValid; ≥ 1
- FV_TRAIL_CC, 4: cycles with FrameValid high after last LineValid; ≥ 1
- STROBE_CC, 8: snapshot strobe pulse width; ≥ 1

Ports:
- piul1Clock  in  1  single clock
- piul1Reset_n  in  1  synchronous reset, active-low
- piul1Enable  in  1  continuous mode: free-running frames while high
- piul1SnapshotMode  in  1  1 = one frame per trigger; 0 = continuous
- piul1SnapshotTrigger  in  1  level; sampled only in IDLE
- poul1FrameValid  out  1  frame valid
- poul1LineValid  out  1  line valid; pixel data qualifier
- poul12PixelData  out  12  pixel; 0 whenever LineValid = 0
- poul1SnapshotStrobe  out  1  high during STROBE state
- poul16FrameCount  out  16  completed frames; wraps 0xFFFF→0x0000

## Operation
- All outputs are registered. Reset drives every output to 0, enters IDLE, and clears the row, column, timer and frame counters. Reset applied mid-frame takes effect on the next edge; there is no trailing pulse.
- States and per-state outputs (FV/LV):
  - IDLE: 0/0.
    - Continuous mode with Enable = 1 → FV_LEAD.
    - Snapshot mode with Trigger = 1 → STROBE.
  - STROBE: 0/0, strobe = 1 for STROBE_CC cycles → FV_LEAD.
  - FV_LEAD: 1/0 for FV_LEAD_CC cycles → ACTIVE.
  - ACTIVE: 1/1 for ACTIVE_COLS cycles. Column counts 0..ACTIVE_COLS-1.
    - At the last column: if row = ACTIVE_ROWS-1 → FV_TRAIL; else → HBLANK.
  - HBLANK: 1/0 for HBLANK_CC cycles, row+1 → ACTIVE.
  - FV_TRAIL: 1/0 for FV_TRAIL_CC cycles → VBLANK. FrameCount increments on this exit.
  - VBLANK: 0/0 for VBLANK_CC cycles.
    - Continuous mode with Enable = 1 → FV_LEAD; otherwise → IDLE. Row and frame position reset.
- Enable or SnapshotMode changes mid-frame: the frame completes unchanged. The new value is acted on only at the VBLANK exit or in IDLE.
- Trigger outside IDLE is ignored. There is no queuing.
- Frame count wraps silently.

## Timing
- FrameValid rises one cycle after Enable, or the end of STROBE, is first sampled in IDLE.
- The first LineValid rises FV_LEAD_CC cycles after FrameValid rises.
- The LineValid falling edge precedes the FrameValid falling edge by FV_TRAIL_CC cycles.
- FrameValid high per frame: FV_LEAD_CC + ACTIVE_ROWS·ACTIVE_COLS + (ACTIVE_ROWS-1)·HBLANK_CC + FV_TRAIL_CC cycles.
- Continuous frame period = the FrameValid-high count above + VBLANK_CC.
- Pixel data is valid in the same cycle as LineValid. The pixel pattern adds no extra latency.

## Configuration
- TRDB_D5M_PIXEL_SOURCE_COLORBARS_EN defined: Bayer colour bars.
  - 8 vertical bars, each ACTIVE_COLS/8 wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bayer position:
    - even row: even column = G, odd column = R;
    - odd row: even column = B, odd column = G.
  - Pixel = 12'hFFF if the bar contains that component, else 0.
- Undefined: ramp, pixel = (row + column + FrameCount) mod 4096. All three operands are zero-extended; the sum is truncated to 12 bits.

## Test plan
Common parameters: COLS=16, ROWS=4, HBLANK=4, VBLANK=6, LEAD=2, TRAIL=2, STROBE=3.

- Continuous, ramp, Enable held high:
  - FrameValid high 80 cycles, period 86.
  - 4 LineValid pulses of 16 cycles, 4-cycle gaps.
  - Frame 0: row1 col15 = 16. Frame 1: row0 col0 = 1. FrameCount = 2 after two frames.
- Colour bars, pixel values:
  - row0 col0 = FFF.
  - row1 col2 (B, yellow) = 0; row1 col3 = FFF.
  - row0 col13 (R, blue) = 0; row1 col12 = FFF.
  - cols 14–15 = 0.
- Snapshot mode, one-cycle Trigger pulse in IDLE:
  - Strobe high 3 cycles, then FrameValid rises next cycle.
  - Exactly one frame, then IDLE.
  - A second Trigger during ACTIVE is ignored.
- Enable dropped mid ACTIVE row 1: the frame completes (80 FV-high cycles), then IDLE after VBLANK. No further FrameValid.
- Reset asserted during HBLANK: the next edge gives all outputs 0 and FrameCount = 0. After release with Enable = 1, the first pixel is row0 col0.
- FrameCount preset via force to 0xFFFF: one frame later it reads 0x0000.
